// File: rtl/uart_pkg.sv
// ============================================================================
// Module  : uart_pkg
// Brief   : Shared UART constants, baud-rate table, window helpers and the
//           autobaud detector state encoding.
// Revision: 1.0
// ============================================================================
`default_nettype none

package uart_pkg;

    typedef enum logic [2:0] {
        IDLE       = 3'd0,
        WAIT_START = 3'd1,
        MEASURE    = 3'd2,
        EVAL       = 3'd3,
        LOCKED     = 3'd4,
        ERROR      = 3'd5
    } abd_state_t;

    localparam int c_num_rates = 9;

    // Ascending order; index 0 (slowest rate) also sets the measurement timeout.
    localparam int unsigned c_rate_table [c_num_rates] = '{
        1200, 2400, 4800, 9600, 14400, 19200, 38400, 57600, 115200
    };

    localparam int unsigned c_default_baud = 115200;
    localparam int unsigned c_oversample   = 16;

    function automatic int unsigned nominal_count(input int unsigned clk_freq,
                                                  input int unsigned rate);
        return clk_freq / rate;
    endfunction

    function automatic int unsigned window_lo(input int unsigned nom);
        return nom - (nom >> 3);
    endfunction

    function automatic int unsigned window_hi(input int unsigned nom);
        return nom + (nom >> 3);
    endfunction

    function automatic int unsigned timeout_count(input int unsigned clk_freq);
        return window_hi(nominal_count(clk_freq, c_rate_table[0])) + 1;
    endfunction

    // Windows do not overlap, so at most one entry can match.
    function automatic logic [16:0] match_rate(input int unsigned clk_freq,
                                               input logic [16:0] cnt);
        logic [16:0] rate;
        int unsigned nom;
        int unsigned cnt_w;
        rate  = '0;
        cnt_w = {15'd0, cnt};
        for (int i = 0; i < c_num_rates; i++) begin
            nom = nominal_count(clk_freq, c_rate_table[i]);
            if (cnt_w >= window_lo(nom) && cnt_w <= window_hi(nom)) begin
                rate = c_rate_table[i][16:0];
            end
        end
        return rate;
    endfunction

endpackage

`default_nettype wire

// File: rtl/uart_rx_sync.sv
// ============================================================================
// Module  : uart_rx_sync
// Brief   : Two-flop synchronizer for the serial line with rise/fall pulses.
// Revision: 1.0
// ============================================================================
`default_nettype none

module uart_rx_sync (
    input  logic clk,
    input  logic rst,
    input  logic rx,
    output logic rx_sync,
    output logic valid,
    output logic rise,
    output logic fall
);

    logic       r_meta;
    logic       r_sync;
    logic       r_prev;
    logic [1:0] r_vld;

    // valid marks when r_sync holds a real sample rather than its reset value.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_meta <= 1'b1;
            r_sync <= 1'b1;
            r_prev <= 1'b1;
            r_vld  <= 2'b00;
        end else begin
            r_meta <= rx;
            r_sync <= r_meta;
            r_prev <= r_sync;
            r_vld  <= {r_vld[0], 1'b1};
        end
    end

    assign rx_sync = r_sync;
    assign valid   = r_vld[1];
    assign rise    = r_sync & ~r_prev;
    assign fall    = r_prev & ~r_sync;

endmodule

`default_nettype wire

// File: rtl/uart_autobaud_detector.sv
// ============================================================================
// Module  : uart_autobaud_detector
// Brief   : Measures one low pulse on rx and maps it to a standard baud rate.
// Revision: 1.0
// ============================================================================
`default_nettype none

module uart_autobaud_detector
    import uart_pkg::*;
#(
    parameter int unsigned CLK_FREQ = 100_000_000
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        rx,
    input  logic        arm,
    output logic [16:0] Baud_Rate,
    output logic        locked,
    output logic        err,
    output logic        done
);

    localparam logic [16:0] c_timeout = 17'(timeout_count(CLK_FREQ));

    logic        w_rx_s;
    logic        w_rx_valid;
    logic        w_rise;
    logic        w_fall;

    abd_state_t  r_state;
    abd_state_t  w_state_nxt;
    logic [16:0] r_cnt;
    logic [16:0] w_cnt_nxt;
    logic [16:0] r_baud;
    logic [16:0] w_baud_nxt;
    logic [16:0] w_match;
    logic        w_done_nxt;
    logic        r_locked;
    logic        r_err;
    logic        r_done;

    uart_rx_sync u_rx_sync (
        .clk     (clk),
        .rst     (rst),
        .rx      (rx),
        .rx_sync (w_rx_s),
        .valid   (w_rx_valid),
        .rise    (w_rise),
        .fall    (w_fall)
    );

    assign w_match = match_rate(CLK_FREQ, r_cnt);

    always_comb begin
        w_state_nxt = r_state;
        w_cnt_nxt   = r_cnt;
        w_baud_nxt  = r_baud;
        w_done_nxt  = 1'b0;
        case (r_state)
            IDLE: begin
                if (w_rx_valid && w_rx_s) w_state_nxt = WAIT_START;
            end
            WAIT_START: begin
                if (w_fall) begin
                    w_cnt_nxt   = '0;
                    w_state_nxt = MEASURE;
                end
            end
            MEASURE: begin
                // Counter never passes the timeout value, so it cannot wrap.
                if (r_cnt == c_timeout) begin
                    w_state_nxt = ERROR;
                    w_baud_nxt  = '0;
                    w_done_nxt  = 1'b1;
                end else if (w_rise) begin
                    w_state_nxt = EVAL;
                end else if (!w_rx_s) begin
                    w_cnt_nxt = r_cnt + 17'd1;
                end
            end
            EVAL: begin
                w_done_nxt = 1'b1;
                if (w_match != '0) begin
                    w_state_nxt = LOCKED;
                    w_baud_nxt  = w_match;
                end else begin
                    w_state_nxt = ERROR;
                    w_baud_nxt  = '0;
                end
            end
            LOCKED, ERROR: begin
                if (arm) begin
                    w_state_nxt = IDLE;
                    w_baud_nxt  = '0;
                end
            end
            default: begin
                w_state_nxt = IDLE;
                w_baud_nxt  = '0;
            end
        endcase
        if (arm && r_state != LOCKED && r_state != ERROR) begin
            w_state_nxt = IDLE;
            w_cnt_nxt   = '0;
            w_baud_nxt  = '0;
            w_done_nxt  = 1'b0;
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_state  <= IDLE;
            r_cnt    <= '0;
            r_baud   <= '0;
            r_locked <= 1'b0;
            r_err    <= 1'b0;
            r_done   <= 1'b0;
        end else begin
            r_state  <= w_state_nxt;
            r_cnt    <= w_cnt_nxt;
            r_baud   <= w_baud_nxt;
            r_locked <= (w_state_nxt == LOCKED);
            r_err    <= (w_state_nxt == ERROR);
            r_done   <= w_done_nxt;
        end
    end

    assign Baud_Rate = r_baud;
    assign locked    = r_locked;
    assign err       = r_err;
    assign done      = r_done;

endmodule

`default_nettype wire

// File: tb/tb_uart_autobaud_detector.sv
// ============================================================================
// Module  : tb_uart_autobaud_detector
// Brief   : Self-checking bench; pulse lengths are the 100 MHz vectors scaled
//           to a 10 MHz clock to keep the run short.
// Revision: 1.0
// ============================================================================
`default_nettype none

module tb_uart_autobaud_detector;

    localparam int CLK_FREQ = 10_000_000;
    localparam int NOM1200  = CLK_FREQ / 1200;
    localparam int TIMEOUT  = NOM1200 + NOM1200 / 8 + 1;

    logic        clk = 1'b0;
    logic        rst = 1'b0;
    logic        rx  = 1'b1;
    logic        arm = 1'b0;
    logic [16:0] Baud_Rate;
    logic        locked;
    logic        err;
    logic        done;

    logic [16:0] exp_baud   = '0;
    logic        exp_locked = 1'b0;
    logic        exp_err    = 1'b0;
    logic        exp_done   = 1'b0;
    int          n_tests    = 0;
    int          n_fail     = 0;

    always #5 clk = ~clk;

    uart_autobaud_detector #(.CLK_FREQ(CLK_FREQ)) dut (
        .clk       (clk),
        .rst       (rst),
        .rx        (rx),
        .arm       (arm),
        .Baud_Rate (Baud_Rate),
        .locked    (locked),
        .err       (err),
        .done      (done)
    );

    // Rate whose +/-12.5% window holds cnt, or 0.
    function automatic int rate_for(input int cnt);
        int rates [9];
        int nom;
        rates = '{1200, 2400, 4800, 9600, 14400, 19200, 38400, 57600, 115200};
        rate_for = 0;
        foreach (rates[i]) begin
            nom = CLK_FREQ / rates[i];
            if (cnt >= nom - nom / 8 && cnt <= nom + nom / 8) rate_for = rates[i];
        end
    endfunction

    task automatic check(input string name, input logic [31:0] got, input logic [31:0] want);
        n_tests++;
        if (got !== want) begin
            n_fail++;
            $display("FAIL %s: got %0d, want %0d", name, got, want);
        end
    endtask

    task automatic compare_loop();
        forever begin
            @(negedge clk);
            n_tests++;
            if (Baud_Rate !== exp_baud || locked !== exp_locked ||
                err !== exp_err || done !== exp_done) begin
                n_fail++;
                $display("FAIL cycle_check t=%0t: got baud=%0d locked=%b err=%b done=%b, want baud=%0d locked=%b err=%b done=%b",
                         $time, Baud_Rate, locked, err, done,
                         exp_baud, exp_locked, exp_err, exp_done);
            end
        end
    endtask

    // Low pulse of n cycles; the model predicts the outcome n-1 counts after
    // the sync/eval pipeline, or the timeout if the pulse is too long.
    task automatic low_pulse(input int n);
        int cnt;
        int done_at;
        int rate;
        int last;
        cnt = n - 1;
        if (exp_locked || exp_err) begin
            done_at = -1;
            rate    = 0;
        end else if (cnt >= TIMEOUT) begin
            done_at = TIMEOUT + 4;
            rate    = 0;
        end else begin
            done_at = n + 4;
            rate    = rate_for(cnt);
        end
        last = ((n > done_at) ? n : done_at) + 1;
        @(posedge clk); #1 rx = 1'b0;
        for (int k = 1; k <= last; k++) begin
            @(posedge clk); #1;
            if (k == n) rx = 1'b1;
            if (k == done_at) begin
                exp_done   = 1'b1;
                exp_baud   = 17'(rate);
                exp_locked = (rate != 0);
                exp_err    = (rate == 0);
            end
            if (k == done_at + 1) exp_done = 1'b0;
        end
        repeat (6) @(posedge clk);
        #1;
    endtask

    task automatic do_arm();
        @(posedge clk); #1 arm = 1'b1;
        @(posedge clk); #1 arm = 1'b0;
        exp_baud   = '0;
        exp_locked = 1'b0;
        exp_err    = 1'b0;
    endtask

    int bnd_len  [4] = '{77, 76, 97, 98};
    int bnd_rate [4] = '{115200, 0, 115200, 0};

    initial begin
        fork
            compare_loop();
        join_none

        repeat (3) @(posedge clk);
        #1;
        check("reset_baud", 32'(Baud_Rate), 0);
        check("reset_locked", 32'(locked), 0);
        check("reset_err", 32'(err), 0);
        check("reset_done", 32'(done), 0);
        rst = 1'b1;
        repeat (6) @(posedge clk);
        #1;

        low_pulse(1042);
        check("lock_9600", 32'(Baud_Rate), 9600);
        check("lock_9600_locked", 32'(locked), 1);
        check("lock_9600_err", 32'(err), 0);

        do_arm();
        check("arm_unlock", 32'(locked), 0);
        low_pulse(4167);
        check("lock_2400", 32'(Baud_Rate), 2400);

        do_arm();
        low_pulse(87);
        check("lock_115200", 32'(Baud_Rate), 115200);
        low_pulse(8334);
        check("ignore_when_locked", 32'(Baud_Rate), 115200);
        check("ignore_when_locked_lk", 32'(locked), 1);

        do_arm();
        low_pulse(840);
        check("gap_err", 32'(err), 1);
        check("gap_baud", 32'(Baud_Rate), 0);

        do_arm();
        low_pulse(12000);
        check("timeout_err", 32'(err), 1);
        check("timeout_locked", 32'(locked), 0);

        for (int i = 0; i < 4; i++) begin
            do_arm();
            low_pulse(bnd_len[i]);
            check("window_edge", 32'(Baud_Rate), 32'(bnd_rate[i]));
        end

        // arm during MEASURE discards the partial count
        do_arm();
        rx = 1'b0;
        repeat (300) @(posedge clk);
        do_arm();
        repeat (200) @(posedge clk);
        #1 rx = 1'b1;
        repeat (8) @(posedge clk);
        #1;
        check("arm_midmeasure_done", 32'(done), 0);
        low_pulse(261);
        check("lock_38400", 32'(Baud_Rate), 38400);

        // reset mid-measurement, released while rx is still low
        do_arm();
        repeat (4) @(posedge clk);
        #1 rx = 1'b0;
        repeat (500) @(posedge clk);
        #1 rst = 1'b0;
        repeat (3) @(posedge clk);
        #1 rst = 1'b1;
        repeat (100) @(posedge clk);
        #1;
        check("post_reset_baud", 32'(Baud_Rate), 0);
        check("post_reset_err", 32'(err), 0);
        rx = 1'b1;
        repeat (10) @(posedge clk);
        #1;
        check("post_reset_rise_ignored", 32'(locked), 0);
        low_pulse(174);
        check("lock_57600", 32'(Baud_Rate), 57600);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule

`default_nettype wire

// File: doc/uart_autobaud_detector.md
UART_AUTOBAUD_DETECTOR -- requirements
Module: uart_autobaud_detector

Interface
REQ-001 SHALL have parameter CLK_FREQ, default 100_000_000, system clock frequency in Hz.
REQ-002 SHALL have port clk  input  1  system clock; all state on rising edge.
REQ-003 SHALL have port rst  input  1  reset, asynchronous, active-low.
REQ-004 SHALL have port rx  input  1  asynchronous serial line, idle high.
REQ-005 SHALL have port arm  input  1  one-cycle request to discard the current result and re-measure.
REQ-006 SHALL have port Baud_Rate  output  17  detected standard baud rate, 0 when none.
REQ-007 SHALL have port locked  output  1  high while Baud_Rate holds a valid detection.
REQ-008 SHALL have port err  output  1  high while the last measurement was invalid.
REQ-009 SHALL have port done  output  1  one-cycle pulse when a measurement finishes, valid or not.

Function
REQ-010 SHALL pass rx through a 2-flop synchronizer; all edge detection and counting use the synchronized value.
REQ-011 SHALL implement states IDLE, WAIT_START, MEASURE, EVAL, LOCKED, ERROR.
REQ-012 IDLE: stay until synchronized rx has been high for one cycle, then go to WAIT_START; a low line at entry is never measured.
REQ-013 WAIT_START: on the falling edge of synchronized rx, clear the 17-bit counter and go to MEASURE.
REQ-014 MEASURE: increment the counter every cycle while rx is low; on a rising edge, latch the count and go to EVAL.
REQ-015 MEASURE timeout: when the count reaches the 1200-baud upper bound + 1 (93750 at the default CLK_FREQ), go to ERROR without waiting for a rising edge.
REQ-016 Nominal count per rate SHALL be CLK_FREQ/rate, truncated. The window SHALL be [nom - (nom>>3), nom + (nom>>3)], inclusive.
REQ-017 Rate table SHALL be 1200, 2400, 4800, 9600, 14400, 19200, 38400, 57600, 115200. Windows do not overlap.
REQ-018 EVAL SHALL take exactly one cycle. If the count is in a window, go to LOCKED with Baud_Rate = that rate; otherwise go to ERROR.
REQ-019 done SHALL pulse for one cycle in the cycle after EVAL (LOCKED or ERROR entry), including on timeout.
REQ-020 LOCKED: locked=1, err=0, Baud_Rate held; rx activity ignored.
REQ-021 ERROR: err=1, locked=0, Baud_Rate=0; rx activity ignored.
REQ-022 arm in LOCKED or ERROR SHALL clear locked, err and Baud_Rate next cycle and go to IDLE.
REQ-023 arm in any other state SHALL restart from IDLE and discard any partial count.
REQ-024 No arithmetic SHALL overflow; the counter saturates by construction at the timeout value.

Reset
REQ-025 With rst low: state=IDLE, counter=0, synchronizer flops=1, Baud_Rate=0, locked=0, err=0, done=0.
REQ-026 Reset asserted mid-MEASURE SHALL abort with no done pulse. After release, a still-low rx SHALL NOT be measured until rx has returned high.

Structure
REQ-027 The rate table, the nominal-count/window functions and the state encoding SHALL live in the shared package uart_pkg, together with the baud constants used by uart_baud_generator.
REQ-028 Sub-module uart_rx_sync SHALL provide the 2-flop synchronizer plus the rise/fall pulse outputs.
REQ-029 The block SHALL be standalone, without instantiating uart_baud_generator.

Verification (CLK_FREQ=100_000_000, 10 ns clock)
REQ-030 rx low for 10417 cycles then high -> Baud_Rate=9600, locked=1, err=0, one done pulse.
REQ-031 rx low for 868 cycles -> Baud_Rate=115200, locked=1. Then rx low for 83333 cycles without arm -> outputs unchanged.
REQ-032 rx low for 8400 cycles (between the 14400 and 9600 windows) -> err=1, Baud_Rate=0, locked=0, one done pulse.
REQ-033 rx held low for 200000 cycles -> err=1 and done when the count reaches 93750, before rx rises.
REQ-034 rst low at count ~5000 in MEASURE, released with rx still low -> all outputs 0 and no done. Then rx high followed by a 1736-cycle low -> Baud_Rate=57600.
REQ-035 arm pulse while locked at 9600, then a 41667-cycle low -> locked drops the cycle after arm, then Baud_Rate=2400, locked=1.
